bpu_satcnt_queue: RTL and testbench



---
 rtl/bpu_pkg.sv | 18 +
 rtl/bpu_satcnt_qctl.sv | 47 ++++
 rtl/bpu_satcnt_queue.sv | 107 ++++++++++
 tb/tb_bpu_satcnt_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and saturating-step helper for the BPU prediction-counter blocks.
package bpu_pkg;

  localparam int unsigned SATCNT_W = 2;

  typedef logic [SATCNT_W-1:0] satcnt_t;

  localparam satcnt_t SATCNT_MAX = '1;
  localparam satcnt_t SATCNT_MIN = '0;

  // Clamped +/-1 step; 'max' carries the saturation ceiling so any counter width can share it.
  function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic [31:0] max,
                                           input logic taken);
    if (taken) return (cnt >= max) ? max : cnt + 32'd1;
    return (cnt <= 32'(SATCNT_MIN)) ? 32'(SATCNT_MIN) : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bpu_satcnt_qctl.sv
// Head/tail pointer control for the saturating-counter queue: occupancy and status flags.
module bpu_satcnt_qctl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH)-1:0]     o_head_idx,
  output logic [$clog2(DEPTH)-1:0]     o_tail_idx,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_afull
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_TH);

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW-1:0] occ;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (i_push) tail_q <= tail_q + PW'(1);
      if (i_pop)  head_q <= head_q + PW'(1);
    end
  end

  assign occ        = tail_q - head_q;
  assign o_head_idx = head_q[AW-1:0];
  assign o_tail_idx = tail_q[AW-1:0];
  assign o_count    = CW'(occ);
  assign o_empty    = (head_q == tail_q);
  assign o_full     = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign o_afull    = (occ >= AFULL_C);

endmodule

// File: rtl/bpu_satcnt_queue.sv
// In-order queue of in-flight prediction counters with in-place saturating training,
// flush, empty bypass and occupancy reporting.
module bpu_satcnt_queue
  import bpu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = SATCNT_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned AFULL_TH  = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [CNT_WIDTH-1:0]         i_push_cnt,
  output logic [$clog2(DEPTH)-1:0]     o_push_idx,
  input  logic                         i_pop,
  output logic [CNT_WIDTH-1:0]         o_rd_cnt,
  output logic                         o_rd_valid,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_afull,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  input  logic                         i_upd,
  input  logic [$clog2(DEPTH)-1:0]     i_upd_idx,
  input  logic                         i_upd_taken,
  output logic                         o_upd_err,
  input  logic                         i_flush
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam bit          BYP = (BYPASS != 0);
  localparam logic [31:0] CNT_MAX = (CNT_WIDTH == SATCNT_W) ? 32'(SATCNT_MAX)
                                  : 32'((64'd1 << CNT_WIDTH) - 64'd1);

  logic [CNT_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     valid_q;

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;

  logic live;
  logic byp_c;
  logic pop_eff;
  logic push_eff;
  logic store_push;
  logic store_pop;
  logic upd_res;
  logic upd_hit;
  logic upd_miss;

  bpu_satcnt_qctl #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) u_qctl (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (i_flush),
    .i_push     (store_push),
    .i_pop      (store_pop),
    .o_head_idx (head_idx),
    .o_tail_idx (tail_idx),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_afull    (o_afull)
  );

  assign live       = !i_rst && !i_flush;
  assign byp_c      = BYP && o_empty && i_push;
  assign o_rd_valid = byp_c || !o_empty;
  assign o_rd_cnt   = byp_c ? i_push_cnt : mem[head_idx];
  assign o_push_idx = tail_idx;

  assign pop_eff    = i_pop && o_rd_valid;
  assign push_eff   = i_push && (!o_full || pop_eff);
  // A bypassed push+pop never touches storage or pointers.
  assign store_push = live && push_eff && !(byp_c && i_pop);
  assign store_pop  = live && pop_eff && !byp_c;

  assign upd_res  = valid_q[i_upd_idx];
  assign upd_hit  = live && i_upd && upd_res && !(store_pop && (i_upd_idx == head_idx));
  assign upd_miss = live && i_upd && !upd_res;

  // Storage is never cleared; valid bits alone define residency.
  always_ff @(posedge i_clk) begin
    if (upd_hit)
      mem[i_upd_idx] <= CNT_WIDTH'(sat_step(32'(mem[i_upd_idx]), CNT_MAX, i_upd_taken));
    if (store_push)
      mem[tail_idx] <= i_push_cnt;
  end

  // When full, push and pop share one slot; the set must win over the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      valid_q <= '0;
    end else begin
      if (store_pop)  valid_q[head_idx] <= 1'b0;
      if (store_push) valid_q[tail_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_upd_err <= 1'b0;
    else       o_upd_err <= upd_miss;
  end

endmodule

// File: tb/tb_bpu_satcnt_queue.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-level model.
module tb_bpu_satcnt_queue;

  localparam int DEPTH = 8;
  localparam int TH    = 6;
  localparam int MAXV  = 3;

  logic       clk = 1'b0;
  logic       rst, push, pop, upd, taken, flush;
  logic [1:0] push_cnt;
  logic [2:0] upd_idx;

  logic [2:0] push_idx, nb_push_idx;
  logic [1:0] rd_cnt, nb_rd_cnt;
  logic       rd_valid, empty, full, afull, upd_err;
  logic       nb_rd_valid, nb_empty, nb_full, nb_afull, nb_upd_err;
  logic [3:0] count, nb_count;

  int checks = 0;
  int errors = 0;
  int q[$];
  int mhead = 0;
  bit merr  = 1'b0;

  bpu_satcnt_queue #(.CNT_WIDTH(2), .DEPTH(8), .BYPASS(1), .AFULL_TH(6)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_cnt(push_cnt), .o_push_idx(push_idx),
    .i_pop(pop), .o_rd_cnt(rd_cnt), .o_rd_valid(rd_valid), .o_empty(empty), .o_full(full),
    .o_afull(afull), .o_count(count), .i_upd(upd), .i_upd_idx(upd_idx),
    .i_upd_taken(taken), .o_upd_err(upd_err), .i_flush(flush)
  );

  bpu_satcnt_queue #(.CNT_WIDTH(2), .DEPTH(8), .BYPASS(0), .AFULL_TH(6)) u_nb (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_cnt(push_cnt), .o_push_idx(nb_push_idx),
    .i_pop(pop), .o_rd_cnt(nb_rd_cnt), .o_rd_valid(nb_rd_valid), .o_empty(nb_empty),
    .o_full(nb_full), .o_afull(nb_afull), .o_count(nb_count), .i_upd(upd),
    .i_upd_idx(upd_idx), .i_upd_taken(taken), .o_upd_err(nb_upd_err), .i_flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit r, input bit f, input bit pu, input int c, input bit po,
                     input bit u, input int ix, input bit t);
    rst = r; flush = f; push = pu; push_cnt = 2'(c); pop = po;
    upd = u; upd_idx = 3'(ix); taken = t;
  endtask

  // Compare every observable output against the queue model for the current inputs.
  task automatic tick();
    bit byp;
    bit vld;
    #1;
    byp = push && (q.size() == 0);
    vld = byp || (q.size() > 0);
    chk("empty",    int'(empty),    int'(q.size() == 0));
    chk("full",     int'(full),     int'(q.size() == DEPTH));
    chk("afull",    int'(afull),    int'(q.size() >= TH));
    chk("count",    int'(count),    q.size());
    chk("rd_valid", int'(rd_valid), int'(vld));
    chk("push_idx", int'(push_idx), (mhead + q.size()) % DEPTH);
    chk("upd_err",  int'(upd_err),  int'(merr));
    if (vld) chk("rd_cnt", int'(rd_cnt), byp ? int'(push_cnt) : q[0]);
  endtask

  task automatic model_update();
    bit byp, vld, pe, pu, res;
    int k, v;
    if (rst || flush) begin
      q.delete();
      mhead = 0;
      merr  = 1'b0;
    end else begin
      byp = push && (q.size() == 0);
      vld = byp || (q.size() > 0);
      pe  = pop && vld;
      pu  = push && ((q.size() < DEPTH) || pe);
      k   = (int'(upd_idx) - mhead + DEPTH) % DEPTH;
      res = (k < q.size());
      merr = upd && !res;
      if (upd && res && !(pe && !byp && k == 0)) begin
        v = q[k];
        q[k] = taken ? ((v < MAXV) ? v + 1 : v) : ((v > 0) ? v - 1 : 0);
      end
      if (!(byp && pop)) begin
        if (pe) begin
          void'(q.pop_front());
          mhead = (mhead + 1) % DEPTH;
        end
        if (pu) q.push_back(int'(push_cnt));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); adv();
  endtask

  int exp_tr[6] = '{3, 3, 2, 1, 0, 0};
  int exp_wrap[8] = '{0, 1, 2, 3, 3, 2, 1, 0};

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    adv();

    // Reset state, then single push visible next cycle.
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_empty", int'(empty), 1); chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(rd_valid), 0); chk("rst_push_idx", int'(push_idx), 0);
    adv();
    drv(0, 0, 1, 3, 0, 0, 0, 0); tick(); chk("push_byp_cnt", int'(rd_cnt), 3); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("push1_cnt", int'(rd_cnt), 3); chk("push1_count", int'(count), 1); adv();
    drv(0, 1, 0, 0, 0, 0, 0, 0); tick(); adv();

    // Fill to full, drop a ninth push, drain in order.
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 1, i % 4, 0, 0, 0, 0); tick();
      chk("fill_afull", int'(afull), int'(i >= 6));
      adv();
    end
    drv(0, 0, 1, 1, 0, 0, 0, 0); tick();
    chk("full_flag", int'(full), 1); chk("full_count", int'(count), 8); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("drop_count", int'(count), 8); adv();
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0); tick(); chk("drain_cnt", int'(rd_cnt), i % 4); adv();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("drain_empty", int'(empty), 1); adv();

    // Empty bypass vs no-bypass instance.
    drv(0, 0, 1, 2, 1, 0, 0, 0); tick();
    chk("byp_cnt", int'(rd_cnt), 2); chk("byp_valid", int'(rd_valid), 1);
    chk("nb_valid", int'(nb_rd_valid), 0);
    adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("byp_count", int'(count), 0); chk("nb_count", int'(nb_count), 1); adv();
    drv(0, 1, 0, 0, 0, 0, 0, 0); tick(); adv();

    // Training saturation on slot 0.
    drv(0, 0, 1, 3, 0, 0, 0, 0); tick(); adv();
    drv(0, 0, 1, 1, 0, 0, 0, 0); tick(); adv();
    for (int k = 0; k < 6; k++) begin
      drv(0, 0, 0, 0, 0, 1, 0, int'(k < 2)); tick(); adv();
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("train_val", int'(rd_cnt), exp_tr[k]); adv();
    end

    // Non-resident update raises a one-cycle error.
    drv(0, 0, 0, 0, 0, 1, 5, 1); tick(); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("miss_err", int'(upd_err), 1); chk("miss_keep", int'(rd_cnt), 0); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("miss_err_clr", int'(upd_err), 0); adv();

    // Update on the head while it pops: dropped silently.
    drv(0, 0, 0, 0, 1, 1, 0, 1); tick(); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("pophead_err", int'(upd_err), 0); chk("pophead_cnt", int'(rd_cnt), 1);
    chk("pophead_count", int'(count), 1); adv();

    // Flush overrides push and update.
    drv(0, 1, 1, 2, 0, 1, 7, 1); tick(); adv();
    drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("flush_count", int'(count), 0); chk("flush_empty", int'(empty), 1);
    chk("flush_err", int'(upd_err), 0); adv();

    // Push+pop while full keeps occupancy and order across the wrap.
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 1, i % 4, 0, 0, 0, 0); tick(); adv();
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 3 - i, 1, 0, 0, 0); tick(); chk("wrap_head", int'(rd_cnt), i); adv();
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick(); chk("wrap_count", int'(count), 8); adv();
    end
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 0, 1, 0, 0, 0); tick(); chk("wrap_order", int'(rd_cnt), exp_wrap[i]); adv();
    end
    idle_step();

    // Randomized traffic; pop pressure alternates to sweep occupancy.
    for (int n = 0; n < 4000; n++) begin
      int pop_th;
      pop_th = ((n / 400) % 2 == 1) ? 3 : 7;
      drv(($urandom % 300) == 0, ($urandom % 80) == 0, ($urandom % 10) < 6,
          int'($urandom % 4), ($urandom % 10) < pop_th, ($urandom % 3) == 0,
          int'($urandom % 8), $urandom % 2 == 1);
      tick();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
